// File: rtl/superres_pkg.sv
// Shared definitions for the superresolution window fetch path: FSM encodings,
// neighbourhood tap geometry and the coordinate clamp used for border replication.
package superres_pkg;

  localparam int NUM_TAPS = 9;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_DRAIN   = 3'd2;
  localparam logic [2:0] S_PRESENT = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  // Tap k covers offset (k%3-1, k/3-1) around the centre pixel
  function automatic int tap_dx(input int k);
    return (k % 3) - 1;
  endfunction

  function automatic int tap_dy(input int k);
    return (k / 3) - 1;
  endfunction

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  // Counter width that stays at least one bit for degenerate single-pixel axes
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/window_addr_gen.sv
// Combinational BRAM address for one 3x3 tap: clamps the tap coordinate to the
// frame and adds the clamped column to the matching precomputed row base.
module window_addr_gen
  import superres_pkg::*;
#(
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 240,
  parameter int ADDR_WIDTH = 17,
  parameter int XW         = 9,
  parameter int YW         = 8
) (
  input  logic [XW-1:0]         x,
  input  logic [YW-1:0]         y,
  input  logic [3:0]            tap,
  input  logic [ADDR_WIDTH-1:0] base_m,
  input  logic [ADDR_WIDTH-1:0] base_c,
  input  logic [ADDR_WIDTH-1:0] base_p,
  output logic [ADDR_WIDTH-1:0] addr
);

  int xc;
  int yc;
  logic [ADDR_WIDTH-1:0] row;

  always_comb begin
    xc = clamp(int'(x) + tap_dx(int'(tap)), 0, WIDTH - 1);
    yc = clamp(int'(y) + tap_dy(int'(tap)), 0, HEIGHT - 1);
    // A clamped row that lands back on y reuses the centre base
    if (yc < int'(y))      row = base_m;
    else if (yc > int'(y)) row = base_p;
    else                   row = base_c;
    addr = row + ADDR_WIDTH'(xc);
  end

endmodule

// File: rtl/window_fetch_scheduler.sv
// Raster-order frame sweep that gathers each pixel's 3x3 neighbourhood from the
// frame buffer and hands the assembled window to the core over valid/ready.
module window_fetch_scheduler
  import superres_pkg::*;
#(
  parameter int WIDTH       = 320,
  parameter int HEIGHT      = 240,
  parameter int PIXEL_WIDTH = 24,
  parameter int ADDR_WIDTH  = 17
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  output logic                            busy,
  output logic                            frame_done,
  output logic                            bram_en,
  output logic [ADDR_WIDTH-1:0]           bram_addr,
  input  logic [PIXEL_WIDTH-1:0]          bram_dout,
  output logic                            win_valid,
  input  logic                            win_ready,
  output logic [NUM_TAPS*PIXEL_WIDTH-1:0] win_data,
  output logic [cw(WIDTH)-1:0]            win_x,
  output logic [cw(HEIGHT)-1:0]           win_y
);

  localparam int XW = cw(WIDTH);
  localparam int YW = cw(HEIGHT);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(WIDTH);
  localparam logic [XW-1:0]         X_LAST   = XW'(WIDTH - 1);
  localparam logic [YW-1:0]         Y_LAST   = YW'(HEIGHT - 1);
  localparam logic [3:0]            TAP_LAST = 4'(NUM_TAPS - 1);

  logic [2:0]             state;
  logic [XW-1:0]          x;
  logic [YW-1:0]          y;
  logic [3:0]             tap;
  logic [3:0]             cap_tap;
  logic                   cap_en;
  logic [ADDR_WIDTH-1:0]  base_m, base_c, base_p;
  logic [ADDR_WIDTH-1:0]  gen_addr;
  logic [PIXEL_WIDTH-1:0] taps [NUM_TAPS];

  window_addr_gen #(
    .WIDTH      (WIDTH),
    .HEIGHT     (HEIGHT),
    .ADDR_WIDTH (ADDR_WIDTH),
    .XW         (XW),
    .YW         (YW)
  ) u_addr_gen (
    .x      (x),
    .y      (y),
    .tap    (tap),
    .base_m (base_m),
    .base_c (base_c),
    .base_p (base_p),
    .addr   (gen_addr)
  );

  always_comb begin
    busy       = (state == S_FETCH) || (state == S_DRAIN) || (state == S_PRESENT);
    frame_done = (state == S_DONE);
    bram_en    = (state == S_FETCH);
    bram_addr  = bram_en ? gen_addr : '0;
    win_valid  = (state == S_PRESENT);
    win_x      = x;
    win_y      = y;
    for (int unsigned k = 0; k < NUM_TAPS; k++)
      win_data[k*PIXEL_WIDTH +: PIXEL_WIDTH] = taps[k];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      x       <= '0;
      y       <= '0;
      tap     <= '0;
      cap_tap <= '0;
      cap_en  <= 1'b0;
      base_m  <= '0;
      base_c  <= '0;
      base_p  <= '0;
      for (int unsigned k = 0; k < NUM_TAPS; k++) taps[k] <= '0;
    end else begin
      // Read data lands one cycle after its request, so capture uses the delayed index
      cap_en  <= bram_en;
      cap_tap <= tap;
      if (cap_en) taps[cap_tap] <= bram_dout;

      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_FETCH;
            x      <= '0;
            y      <= '0;
            tap    <= '0;
            base_m <= '0 - ROW_STEP;
            base_c <= '0;
            base_p <= ROW_STEP;
          end
        end
        S_FETCH: begin
          if (tap == TAP_LAST) begin
            tap   <= '0;
            state <= S_DRAIN;
          end else begin
            tap <= tap + 4'd1;
          end
        end
        S_DRAIN: state <= S_PRESENT;
        S_PRESENT: begin
          if (win_ready) begin
            if (x == X_LAST && y == Y_LAST) begin
              state <= S_DONE;
            end else begin
              state <= S_FETCH;
              if (x == X_LAST) begin
                x      <= '0;
                y      <= y + YW'(1);
                base_m <= base_m + ROW_STEP;
                base_c <= base_c + ROW_STEP;
                base_p <= base_p + ROW_STEP;
              end else begin
                x <= x + XW'(1);
              end
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_window_fetch_scheduler.sv
// Bench for window_fetch_scheduler on a 4x3 frame: directed corner/backpressure/
// reset sequences plus randomized frames checked against a clamp-arithmetic model.
module tb_window_fetch_scheduler;

  localparam int W    = 4;
  localparam int H    = 3;
  localparam int PW   = 24;
  localparam int AW   = 17;
  localparam int NT   = 9;
  localparam int NPIX = W * H;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           busy;
  logic           frame_done;
  logic           bram_en;
  logic [AW-1:0]  bram_addr;
  logic [PW-1:0]  bram_dout;
  logic           win_valid;
  logic           win_ready;
  logic [NT*PW-1:0] win_data;
  logic [1:0]     win_x;
  logic [1:0]     win_y;

  int errors = 0;
  int checks = 0;

  logic [PW-1:0]    mem [NPIX];
  logic [NT*PW-1:0] got [NPIX];

  typedef struct {
    int x;
    int y;
    int t [NT];
  } win_rec_t;
  win_rec_t tbl [5];

  window_fetch_scheduler #(
    .WIDTH       (W),
    .HEIGHT      (H),
    .PIXEL_WIDTH (PW),
    .ADDR_WIDTH  (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .frame_done (frame_done),
    .bram_en    (bram_en),
    .bram_addr  (bram_addr),
    .bram_dout  (bram_dout),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .win_data   (win_data),
    .win_x      (win_x),
    .win_y      (win_y)
  );

  always #5 clk = ~clk;

  // Synchronous-read frame buffer
  always @(posedge clk) if (bram_en) bram_dout <= mem[bram_addr];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  // Neighbourhood straight from the border-replication rule
  function automatic logic [NT*PW-1:0] ref_win(input int x, input int y);
    logic [NT*PW-1:0] r;
    for (int k = 0; k < NT; k++)
      r[k*PW +: PW] = mem[clampi(y + k/3 - 1, H-1) * W + clampi(x + k%3 - 1, W-1)];
    return r;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"},       busy,       0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_bram_en"},    bram_en,    0);
    chk({tag, "_win_valid"},  win_valid,  0);
    chk({tag, "_bram_addr"},  bram_addr,  0);
    chk({tag, "_win_data"},   win_data,   0);
    chk({tag, "_win_x"},      win_x,      0);
    chk({tag, "_win_y"},      win_y,      0);
  endtask

  task automatic quiet_cycles(input string tag, input int n);
    int seen = 0;
    repeat (n) begin
      tick;
      if (bram_en || busy || frame_done || win_valid) seen++;
    end
    chk(tag, seen, 0);
  endtask

  task automatic run_frame(input int ready_pct, input int hold_idx, input int abort_idx,
                           input bit mid_start, output int nwin);
    int cyc = 0;
    int hold = 0;
    int fetch_seen = 0;
    bit fin = 0;
    logic [NT*PW-1:0] snap_d;
    logic [1:0] sx, sy;
    nwin = 0;
    start = 1'b1;
    tick;
    start = 1'b0;
    cyc = 1;
    while (!win_valid && cyc < 40) begin
      tick;
      cyc++;
    end
    chk("first_valid_latency", cyc, 11);
    cyc = 0;
    while (!fin && cyc < 3000) begin
      win_ready = ($urandom_range(99) < ready_pct);
      start = (mid_start && cyc == 30);
      if (win_valid) chk("no_read_while_valid", bram_en, 0);
      if (win_valid && nwin == hold_idx) begin
        if (hold == 0) begin
          snap_d = win_data;
          sx = win_x;
          sy = win_y;
        end else begin
          chk("bp_data", win_data, snap_d);
          chk("bp_x", win_x, sx);
          chk("bp_y", win_y, sy);
        end
        win_ready = (hold >= 5);
        hold++;
      end
      if (abort_idx >= 0 && nwin == abort_idx && bram_en) begin
        fetch_seen++;
        if (fetch_seen == 3) begin
          rst = 1'b1;
          start = 1'b0;
          tick;
          chk_idle("abort");
          rst = 1'b0;
          return;
        end
      end
      if (win_valid && win_ready) begin
        chk("win_x", win_x, nwin % W);
        chk("win_y", win_y, nwin / W);
        chk("win_data", win_data, ref_win(nwin % W, nwin / W));
        if (nwin < NPIX) got[nwin] = win_data;
        nwin++;
      end
      if (frame_done) begin
        chk("windows_before_done", nwin, NPIX);
        chk("busy_at_done", busy, 0);
        start = 1'b1;
        fin = 1;
      end
      tick;
      cyc++;
    end
    if (!fin) chk("frame_timeout", 0, 1);
    start = 1'b0;
    win_ready = 1'b1;
    quiet_cycles("post_done_quiet", 15);
  endtask

  initial begin
    int n;
    logic [NT*PW-1:0] e;

    tbl[0].x = 0; tbl[0].y = 0; tbl[0].t = '{0, 0, 1, 0, 0, 1, 4, 4, 5};
    tbl[1].x = 1; tbl[1].y = 1; tbl[1].t = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    tbl[2].x = 3; tbl[2].y = 2; tbl[2].t = '{6, 7, 7, 10, 11, 11, 10, 11, 11};
    tbl[3].x = 2; tbl[3].y = 0; tbl[3].t = '{1, 2, 3, 1, 2, 3, 5, 6, 7};
    tbl[4].x = 0; tbl[4].y = 2; tbl[4].t = '{4, 4, 5, 8, 8, 9, 8, 8, 9};

    for (int a = 0; a < NPIX; a++) mem[a] = PW'(a);

    rst = 1'b1;
    start = 1'b0;
    win_ready = 1'b1;
    repeat (3) tick;
    chk_idle("reset");
    rst = 1'b0;
    quiet_cycles("idle_no_bram", 20);

    // Address-valued memory, backpressure at window (2,0), ignored mid-frame start
    run_frame(100, 2, -1, 1, n);
    chk("frame1_windows", n, NPIX);
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < NT; k++) e[k*PW +: PW] = PW'(tbl[i].t[k]);
      chk($sformatf("table_win_%0d_%0d", tbl[i].x, tbl[i].y), got[tbl[i].y * W + tbl[i].x], e);
    end

    // Reset during the fetch of window 5, then a clean restart
    run_frame(100, -1, 5, 0, n);
    chk("abort_windows", n, 5);
    quiet_cycles("after_abort_quiet", 20);
    run_frame(100, -1, -1, 0, n);
    chk("restart_windows", n, NPIX);

    for (int f = 0; f < 3; f++) begin
      for (int a = 0; a < NPIX; a++) mem[a] = PW'($urandom);
      run_frame(60, -1, -1, 0, n);
      chk("random_windows", n, NPIX);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
